// File: rtl/sample_stream_scheduler_pkg.sv
// sample_stream_scheduler_pkg
// Shared definitions for the sample stream scheduler:
//   - default WIDTH / DEPTH / PREFILL values
//   - state encoding (IDLE=0, FILL=1, RUN=2, FLUSH=3), exposed on the debug port
//   - sat_inc8: saturating 8-bit increment used by the underrun counter
package sample_stream_scheduler_pkg;

  localparam int DEFAULT_WIDTH   = 16;
  localparam int DEFAULT_DEPTH   = 8;
  localparam int DEFAULT_PREFILL = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/sample_stream_scheduler_if.sv
// sample_stream_scheduler_if
// Groups the generator-side and codec-side stream signals of the scheduler.
//   gen_req          scheduler -> generator  request one sample
//   gen_valid        generator -> scheduler  gen_sample valid this cycle
//   gen_sample       generator -> scheduler  signed sample, WIDTH bits
//   frame_strobe     codec -> scheduler      codec wants one sample
//   sample_out       scheduler -> codec      registered sample
//   sample_out_valid scheduler -> codec      sample_out updated this cycle
//
// Handshake semantics: both streams are pulse based with no back-pressure.
// Every signal named *_req, *_valid or *_strobe is a single-cycle pulse that
// is consumed in the cycle it is high; the receiver must always accept it.
// gen_req / gen_valid form a request/response pair with at most one request
// in flight; each frame_strobe is answered by exactly one sample_out_valid
// pulse one cycle later.
interface sample_stream_scheduler_if
  import sample_stream_scheduler_pkg::*;
  #(parameter int WIDTH = DEFAULT_WIDTH) ();

  logic             gen_req;
  logic             gen_valid;
  logic [WIDTH-1:0] gen_sample;
  logic             frame_strobe;
  logic [WIDTH-1:0] sample_out;
  logic             sample_out_valid;

  // Scheduler side
  modport master (
    output gen_req,
    input  gen_valid,
    input  gen_sample,
    input  frame_strobe,
    output sample_out,
    output sample_out_valid
  );

  // Generator / codec side
  modport slave (
    input  gen_req,
    output gen_valid,
    output gen_sample,
    output frame_strobe,
    input  sample_out,
    input  sample_out_valid
  );

endinterface

// File: rtl/sample_stream_scheduler_fifo.sv
// sample_fifo
// Circular sample buffer with exact occupancy count.
//   clk, reset  clock, asynchronous active-high reset (pointers/level only)
//   clear       synchronous empty (pointers and level to zero), wins over push/pop
//   push, din   write din when not full; a push while full is dropped
//   pop         advance the read pointer when not empty; a pop while empty is ignored
//   head        entry at the read pointer (valid when not empty)
//   full, empty occupancy flags
//   level       occupancy, 0..DEPTH
// DEPTH must be a power of two so pointers wrap by natural overflow.
module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_LEVEL  = 1;
  localparam logic [AW-1:0] ONE_PTR    = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == FULL_LEVEL);
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ONE_PTR;
      if (do_pop)  rd_ptr <= rd_ptr + ONE_PTR;
      // Simultaneous push and pop leaves the level unchanged.
      if (do_push && !do_pop)      level <= level + ONE_LEVEL;
      else if (do_pop && !do_push) level <= level - ONE_LEVEL;
    end
  end

  // Storage carries no reset; only pointers and level define validity.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sample_stream_scheduler.sv
// sample_stream_scheduler
// Buffers generator samples in a FIFO and serves them to a codec on frame
// strobes. Playback starts once PREFILL samples are buffered; dropping
// enable flushes the buffer for one cycle and returns to IDLE.
//   clk, reset      clock, asynchronous active-high reset
//   enable          1 = play, 0 = stop and flush
//   stream          generator/codec stream signals (master side)
//   underrun        pulse: a strobe in RUN found the FIFO empty
//   underrun_count  saturating (255) count of underrun pulses, reset only
//   fill_level      FIFO occupancy, 0..DEPTH
//   state           current state (IDLE=0, FILL=1, RUN=2, FLUSH=3)
module sample_stream_scheduler
  import sample_stream_scheduler_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int PREFILL = DEFAULT_PREFILL
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  sample_stream_scheduler_if.master stream,
  output logic                   underrun,
  output logic [7:0]             underrun_count,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic [1:0]             state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PREFILL_LEVEL = (AW+1)'(PREFILL);

  state_t           state_q;
  state_t           state_d;
  logic             outstanding_q;
  logic             req;
  logic             active;
  logic             in_run;
  logic             flush;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_head;
  logic [WIDTH-1:0] sample_q;
  logic             sample_valid_q;
  logic             underrun_q;
  logic [7:0]       underrun_count_q;

  assign active = (state_q == ST_FILL) || (state_q == ST_RUN);
  assign in_run = (state_q == ST_RUN);
  assign flush  = (state_q == ST_FLUSH);

  // Generator samples are only accepted while the stream is active;
  // the FIFO itself drops a push that arrives while full.
  assign push = stream.gen_valid & active;
  assign pop  = stream.frame_strobe & in_run & ~fifo_empty;

  sample_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .push  (push),
    .din   (stream.gen_sample),
    .pop   (pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fill_level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_FILL;
      end
      ST_FILL: begin
        req = ~outstanding_q & ~fifo_full;
        if (!enable)                          state_d = ST_FLUSH;
        else if (fill_level >= PREFILL_LEVEL) state_d = ST_RUN;
      end
      ST_RUN: begin
        // An underrun does not pause playback for a refill.
        req = ~outstanding_q & ~fifo_full;
        if (!enable) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Request tracking and codec output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding_q    <= 1'b0;
      sample_q         <= '0;
      sample_valid_q   <= 1'b0;
      underrun_q       <= 1'b0;
      underrun_count_q <= '0;
    end else begin
      if (flush)                 outstanding_q <= 1'b0;
      else if (req)              outstanding_q <= 1'b1;
      else if (stream.gen_valid) outstanding_q <= 1'b0;

      // Every strobe gets exactly one valid pulse, whatever the state.
      sample_valid_q <= stream.frame_strobe;
      underrun_q     <= 1'b0;
      if (stream.frame_strobe) begin
        if (in_run) begin
          if (!fifo_empty) begin
            sample_q <= fifo_head;
          end else begin
            // Empty in RUN: hold the last sample and flag it.
            underrun_q       <= 1'b1;
            underrun_count_q <= sat_inc8(underrun_count_q);
          end
        end else begin
          sample_q <= '0;
        end
      end
    end
  end

  assign stream.gen_req          = req;
  assign stream.sample_out       = sample_q;
  assign stream.sample_out_valid = sample_valid_q;
  assign underrun                = underrun_q;
  assign underrun_count          = underrun_count_q;
  assign state                   = state_q;

endmodule

// File: tb/tb_sample_stream_scheduler.sv
// Testbench for sample_stream_scheduler: queue-based reference model,
// automatic generator responder, directed scenario sequence.
module tb_sample_stream_scheduler;

  localparam int WIDTH   = 16;
  localparam int DEPTH   = 8;
  localparam int PREFILL = 4;
  localparam int LW      = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic enable;
  always #5 clk = ~clk;

  sample_stream_scheduler_if #(.WIDTH(WIDTH)) bus ();
  logic          underrun;
  logic [7:0]    underrun_count;
  logic [LW-1:0] fill_level;
  logic [1:0]    state;

  sample_stream_scheduler #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .PREFILL (PREFILL)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .stream         (bus),
    .underrun       (underrun),
    .underrun_count (underrun_count),
    .fill_level     (fill_level),
    .state          (state)
  );

  // ---------------- counters ----------------
  int n_assert = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  // States by number: 0 idle, 1 fill, 2 run, 3 flush.
  logic [WIDTH-1:0] m_q[$];
  int               m_state;
  bit               m_out;
  logic [WIDTH-1:0] m_sout;
  bit               m_valid;
  bit               m_under;
  int               m_count;

  function automatic bit m_req();
    return (m_state == 1 || m_state == 2) && !m_out && (m_q.size() < DEPTH);
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_state = 0;
    m_out   = 0;
    m_sout  = '0;
    m_valid = 0;
    m_under = 0;
    m_count = 0;
  endtask

  task automatic model_step();
    int lvl;
    bit req;
    bit do_pop;
    if (reset) begin
      model_clear();
      return;
    end
    lvl     = m_q.size();
    req     = m_req();
    do_pop  = 0;
    m_valid = bus.frame_strobe;
    m_under = 0;
    if (bus.frame_strobe) begin
      if (m_state == 2) begin
        if (lvl > 0) begin
          m_sout = m_q[0];
          do_pop = 1;
        end else begin
          m_under = 1;
          if (m_count < 255) m_count++;
        end
      end else begin
        m_sout = '0;
      end
    end
    if (do_pop) void'(m_q.pop_front());
    if (bus.gen_valid && (m_state == 1 || m_state == 2) && lvl < DEPTH)
      m_q.push_back(bus.gen_sample);
    if (m_state == 3) begin
      m_out = 0;
      m_q.delete();
    end else if (req) begin
      m_out = 1;
    end else if (bus.gen_valid) begin
      m_out = 0;
    end
    case (m_state)
      0: if (enable) m_state = 1;
      1: if (!enable) m_state = 3; else if (lvl >= PREFILL) m_state = 2;
      2: if (!enable) m_state = 3;
      default: m_state = 0;
    endcase
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("state", state, m_state);
    chk("gen_req", bus.gen_req, m_req());
    chk("fill_level", fill_level, m_q.size());
    chk("sample_out", bus.sample_out, m_sout);
    chk("sample_out_valid", bus.sample_out_valid, m_valid);
    chk("underrun", underrun, m_under);
    chk("underrun_count", underrun_count, m_count);
  endtask

  // ---------------- generator responder / driver tasks ----------------
  bit               gen_auto = 0;
  bit               lat_rand = 0;
  int               gen_lat  = 3;
  int               pend     = -1;
  bit               req_seen = 0;
  int               reqs     = 0;
  int               vals     = 0;
  logic [WIDTH-1:0] next_sample;

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    check_all();
    bus.gen_valid = 1'b0;
    req_seen      = 0;
    if (m_req()) reqs++;
    if (pend > 0) pend--;
    if (pend == 0) begin
      bus.gen_valid  = 1'b1;
      bus.gen_sample = next_sample;
      next_sample++;
      pend = -1;
      vals++;
    end
    if (gen_auto && m_req() && pend < 0) begin
      pend     = lat_rand ? int'($urandom_range(1, 6)) : gen_lat;
      req_seen = 1;
    end
  endtask

  task automatic strobe_pulse();
    bus.frame_strobe = 1'b1;
    tick();
    bus.frame_strobe = 1'b0;
    tick();
  endtask

  task automatic push_manual(input logic [WIDTH-1:0] v);
    bus.gen_valid  = 1'b1;
    bus.gen_sample = v;
    tick();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [WIDTH-1:0] exp_seq;
    logic [WIDTH-1:0] fourth;
    logic [WIDTH-1:0] s0;
    int pops;
    int unders;
    bit late_seen;

    reset            = 1'b1;
    enable           = 1'b1;
    bus.gen_valid    = 1'b0;
    bus.gen_sample   = '0;
    bus.frame_strobe = 1'b0;
    next_sample      = 1;
    model_clear();

    // Reset state, held with enable=1: stays IDLE.
    tick();
    tick();
    chk("reset_state", state, 0);
    reset = 1'b0;

    // Fill: generator answers after 3 cycles until RUN.
    gen_auto = 1;
    gen_lat  = 3;
    for (int i = 0; i < 200; i++) begin
      tick();
      chk("one_outstanding", (reqs - vals) <= 1, 1);
      if (m_state == 2) break;
    end
    chk("run_reached", state, 2);
    chk("prefill_level", fill_level >= PREFILL, 1);

    // Ordered playback, strobe every 20 cycles, random generator latency.
    lat_rand = 1;
    exp_seq  = 1;
    for (int k = 0; k < 10; k++) begin
      repeat (19) tick();
      bus.frame_strobe = 1'b1;
      tick();
      bus.frame_strobe = 1'b0;
      chk("play_seq", bus.sample_out, exp_seq);
      chk("play_valid", bus.sample_out_valid, 1);
      exp_seq++;
    end
    chk("play_no_underrun", underrun_count, 0);

    // Stall generator, drain to 4 entries, then 6 strobes.
    gen_auto = 0;
    for (int i = 0; i < 20 && pend >= 0; i++) tick();
    tick();
    for (int i = 0; i < 10 && m_q.size() > 4; i++) strobe_pulse();
    chk("stall_level", fill_level, 4);
    fourth = m_q[3];
    pops   = 0;
    unders = 0;
    for (int i = 0; i < 6; i++) begin
      bus.frame_strobe = 1'b1;
      tick();
      bus.frame_strobe = 1'b0;
      if (bus.sample_out_valid && !underrun) pops++;
      if (underrun) unders++;
      tick();
    end
    chk("stall_pops", pops, 4);
    chk("stall_underruns", unders, 2);
    chk("stall_hold", bus.sample_out, fourth);
    chk("stall_count", underrun_count, 2);

    // Push and strobe together at level 0.
    s0               = WIDTH'($urandom);
    bus.gen_valid    = 1'b1;
    bus.gen_sample   = s0;
    bus.frame_strobe = 1'b1;
    tick();
    bus.frame_strobe = 1'b0;
    chk("edge0_underrun", underrun, 1);
    chk("edge0_level", fill_level, 1);
    chk("edge0_count", underrun_count, 3);
    chk("edge0_hold", bus.sample_out, fourth);

    // Fill to DEPTH-1, then push and strobe together.
    for (int i = 0; i < DEPTH - 2; i++) push_manual(WIDTH'($urandom));
    chk("edge7_pre_level", fill_level, DEPTH - 1);
    bus.gen_valid    = 1'b1;
    bus.gen_sample   = WIDTH'($urandom);
    bus.frame_strobe = 1'b1;
    tick();
    bus.frame_strobe = 1'b0;
    chk("edge7_level", fill_level, DEPTH - 1);
    chk("edge7_sample", bus.sample_out, s0);
    chk("edge7_no_underrun", underrun, 0);

    // Drop enable with 5 entries.
    strobe_pulse();
    strobe_pulse();
    chk("flush_pre_level", fill_level, 5);
    enable = 1'b0;
    tick();
    chk("flush_state", state, 3);
    tick();
    chk("flush_idle", state, 0);
    chk("flush_level", fill_level, 0);
    for (int i = 0; i < 3; i++) begin
      bus.frame_strobe = 1'b1;
      tick();
      bus.frame_strobe = 1'b0;
      chk("idle_sample", bus.sample_out, 0);
      chk("idle_valid", bus.sample_out_valid, 1);
      tick();
    end
    chk("count_kept", underrun_count, 3);

    // Reset while a request is outstanding and the FIFO is half full.
    enable   = 1'b1;
    gen_auto = 1;
    lat_rand = 0;
    gen_lat  = 6;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (req_seen && m_q.size() == DEPTH / 2) break;
    end
    chk("half_full_found", req_seen && (m_q.size() == DEPTH / 2), 1);
    reset = 1'b1;
    model_clear();
    #1;
    chk("async_state", state, 0);
    chk("async_level", fill_level, 0);
    chk("async_gen_req", bus.gen_req, 0);
    chk("async_sample", bus.sample_out, 0);
    chk("async_valid", bus.sample_out_valid, 0);
    chk("async_underrun", underrun, 0);
    chk("async_count", underrun_count, 0);
    enable = 1'b0;
    tick();
    tick();
    reset     = 1'b0;
    late_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.gen_valid) late_seen = 1;
      chk("late_level", fill_level, 0);
      chk("late_state", state, 0);
    end
    chk("late_valid_sent", late_seen, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
